// File: rtl/seq_shift_unit.sv
// Multi-cycle shift/rotate unit: one bit position per clock under a start/busy/done handshake.
// Result and carry are registered and held until the next accepted operation.
module seq_shift_unit #(
  parameter int unsigned N  = 4,
  parameter int unsigned AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [2:0]    mode,
  input  logic [AW-1:0] amount,
  input  logic [N-1:0]  operand,
  output logic [N-1:0]  result,
  output logic          busy,
  output logic          done,
  output logic          carry,
  output logic          zero
);

  localparam logic [2:0] MODE_LSL = 3'd0;
  localparam logic [2:0] MODE_LSR = 3'd1;
  localparam logic [2:0] MODE_ASR = 3'd2;
  localparam logic [2:0] MODE_ROL = 3'd3;
  localparam logic [2:0] MODE_ROR = 3'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [2:0]    op_mode;
  logic [2:0]    op_mode_next;
  logic [AW-1:0] count;
  logic [AW-1:0] count_next;
  logic [N-1:0]  result_next;
  logic          carry_next;
  logic          busy_next;
  logic          done_next;
  logic          mode_valid;

  // Reserved encodings bypass the shifter and complete immediately
  assign mode_valid = (mode <= MODE_ROR);

  assign zero = (result == '0);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      op_mode <= MODE_LSL;
      count   <= '0;
      result  <= '0;
      carry   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_next;
      op_mode <= op_mode_next;
      count   <= count_next;
      result  <= result_next;
      carry   <= carry_next;
      busy    <= busy_next;
      done    <= done_next;
    end
  end

  // Next-state, single-step datapath and handshake outputs
  always_comb begin
    state_next   = state;
    op_mode_next = op_mode;
    count_next   = count;
    result_next  = result;
    carry_next   = carry;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          result_next  = operand;
          count_next   = amount;
          op_mode_next = mode;
          carry_next   = 1'b0;
          if ((amount != '0) && mode_valid) begin
            state_next = SHIFT;
          end else begin
            state_next = DONE;
          end
        end else begin
          state_next = IDLE;
        end
      end

      SHIFT: begin
        case (op_mode)
          MODE_LSL: begin
            result_next = {result[N-2:0], 1'b0};
            carry_next  = result[N-1];
          end
          MODE_LSR: begin
            result_next = {1'b0, result[N-1:1]};
            carry_next  = result[0];
          end
          MODE_ASR: begin
            result_next = {result[N-1], result[N-1:1]};
            carry_next  = result[0];
          end
          MODE_ROL: begin
            result_next = {result[N-2:0], result[N-1]};
            carry_next  = result[N-1];
          end
          MODE_ROR: begin
            result_next = {result[0], result[N-1:1]};
            carry_next  = result[0];
          end
          default: begin
            result_next = result;
            carry_next  = carry;
          end
        endcase
        count_next = count - AW'(1);
        if (count == AW'(1)) begin
          state_next = DONE;
        end else begin
          state_next = SHIFT;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Handshake flags track the state being entered so they line up with it
    busy_next = (state_next == SHIFT);
    done_next = (state_next == DONE);
  end

endmodule
